// File: rtl/amiga_m68k_bus_pkg.sv
// Shared definitions for the 68000-style bus-cycle initiator.
//   bus_state_e        : bus-cycle state encoding (IDLE, S0, S2, S4, S6, S7)
//   BE_*               : byte-enable patterns ([1] = upper byte, [0] = lower byte)
//   TIMEOUT_CYCLES_DEF : default cap on cycles spent waiting for _DTACK
package amiga_m68k_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S0,
        S2,
        S4,
        S6,
        S7
    } bus_state_e;

    localparam logic [1:0] BE_NONE  = 2'b00;
    localparam logic [1:0] BE_WORD  = 2'b11;
    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_LOWER = 2'b01;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/amiga_sync_ff.sv
// N-stage synchroniser for an asynchronous, active-low level.
// Every stage presets to 1 so the synchronised signal reads inactive out of reset.
//   clk   : sampling clock
//   rst_n : synchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output (last stage)
module amiga_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/amiga_m68k_bus_master.sv
// Master end of an asynchronous 68000 bus cycle, driven by a local REQ/DONE
// handshake. Every bus output is registered; _DTACK is synchronised first.
//   CLK, _RST                : clock (2x 68000 clock), synchronous active-low reset
//   REQ, RW, ADDR, WDATA, BE : local request (REQ sampled only in IDLE)
//   BUSY, DONE, ERR, RDATA   : local status, completion pulse, error flag, read data
//   A, D_OUT, D_OE, D_IN     : bus address, write data, data drive enable, read data
//   _AS, _UDS, _LDS, _PRW    : bus strobes and read/write
//   _DTACK                   : asynchronous acknowledge from the responder
module amiga_m68k_bus_master
    import amiga_m68k_bus_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned TO_W           = 11
) (
    input  logic        CLK,
    input  logic        _RST,
    input  logic        REQ,
    input  logic        RW,
    input  logic [22:0] ADDR,
    input  logic [15:0] WDATA,
    input  logic [1:0]  BE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic [22:0] A,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    input  logic [15:0] D_IN,
    output logic        _AS,
    output logic        _UDS,
    output logic        _LDS,
    output logic        _PRW,
    input  logic        _DTACK
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    bus_state_e        state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              abort;
    logic              dtack_s_n;

    logic [1:0]  be_q, be_d;
    logic [15:0] wdata_q, wdata_d;
    logic [22:0] a_q, a_d;
    logic        prw_q, prw_d;
    logic [15:0] dout_q, dout_d;
    logic        doe_q, doe_d;
    logic        as_n_q, as_n_d;
    logic        uds_n_q, uds_n_d;
    logic        lds_n_q, lds_n_d;
    logic [15:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    amiga_sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_dtack_sync (
        .clk  (CLK),
        .rst_n(_RST),
        .d    (_DTACK),
        .q    (dtack_s_n)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (!_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; abort marks a transition into S7 that ends with ERR
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ) begin
                    state_d = S0;
                    cnt_d   = '0;
                end
            end
            S0: begin
                if (be_q == BE_NONE) begin
                    state_d = S7;
                    abort   = 1'b1;
                end else begin
                    state_d = S2;
                end
            end
            S2: state_d = S4;
            S4: begin
                if (!dtack_s_n) begin
                    state_d = S6;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S7;
                    abort   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S6:      state_d = S7;
            S7:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: bus outputs are computed one cycle early from the
    // transition so the registered value lines up with the state it belongs to.
    always_comb begin
        be_d    = be_q;
        wdata_d = wdata_q;
        a_d     = a_q;
        prw_d   = prw_q;
        dout_d  = dout_q;
        doe_d   = doe_q;
        as_n_d  = as_n_q;
        uds_n_d = uds_n_q;
        lds_n_d = lds_n_q;
        rdata_d = rdata_q;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == S7);
        err_d   = abort;

        if (state_q == IDLE && REQ) begin
            be_d    = BE;
            wdata_d = WDATA;
            // An empty byte enable never touches the bus, so A and _PRW keep their values
            if (BE != BE_NONE) begin
                a_d   = ADDR;
                prw_d = RW;
            end
        end

        if (state_q == S0 && state_d == S2) begin
            as_n_d = 1'b0;
            if (prw_q) begin
                {uds_n_d, lds_n_d} = ~be_q;
            end else begin
                dout_d = wdata_q;
                doe_d  = 1'b1;
            end
        end

        // Write strobes follow the data by one cycle
        if (state_q == S2 && !prw_q) begin
            {uds_n_d, lds_n_d} = ~be_q;
        end

        if (state_q == S6 && prw_q) begin
            rdata_d = D_IN;
        end

        if (state_d == S7) begin
            as_n_d  = 1'b1;
            uds_n_d = 1'b1;
            lds_n_d = 1'b1;
        end

        if (state_q == S7) begin
            doe_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!_RST) begin
            be_q    <= '0;
            wdata_q <= '0;
            a_q     <= '0;
            prw_q   <= 1'b1;
            dout_q  <= '0;
            doe_q   <= 1'b0;
            as_n_q  <= 1'b1;
            uds_n_q <= 1'b1;
            lds_n_q <= 1'b1;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            be_q    <= be_d;
            wdata_q <= wdata_d;
            a_q     <= a_d;
            prw_q   <= prw_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            as_n_q  <= as_n_d;
            uds_n_q <= uds_n_d;
            lds_n_q <= lds_n_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign ERR   = err_q;
    assign RDATA = rdata_q;
    assign A     = a_q;
    assign D_OUT = dout_q;
    assign D_OE  = doe_q;
    assign _AS   = as_n_q;
    assign _UDS  = uds_n_q;
    assign _LDS  = lds_n_q;
    assign _PRW  = prw_q;

endmodule

// File: tb/tb_amiga_m68k_bus_master.sv
// Directed bench for amiga_m68k_bus_master with a small _DTACK responder model.
module tb_amiga_m68k_bus_master;
    import amiga_m68k_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        rw;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        busy, done, err;
    logic [15:0] rdata;
    logic [22:0] a;
    logic [15:0] d_out;
    logic        d_oe;
    logic [15:0] d_in;
    logic        as_n, uds_n, lds_n, prw;
    logic        dtack_n;

    int n_tests = 0;
    int n_fail  = 0;

    // Responder: _DTACK follows _AS after resp_wait cycles, or never
    logic [7:0]  as_hist = '1;
    int          resp_wait = 0;
    logic        resp_never = 1'b0;
    logic [15:0] resp_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) as_hist <= {as_hist[6:0], as_n};

    always_comb begin
        if (resp_never)          dtack_n = 1'b1;
        else if (resp_wait == 0) dtack_n = as_n;
        else                     dtack_n = as_hist[resp_wait-1];
    end

    assign d_in = resp_data;

    amiga_m68k_bus_master #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(16),
        .TO_W          (5)
    ) dut (
        .CLK   (clk),
        ._RST  (rst_n),
        .REQ   (req),
        .RW    (rw),
        .ADDR  (addr),
        .WDATA (wdata),
        .BE    (be),
        .BUSY  (busy),
        .DONE  (done),
        .ERR   (err),
        .RDATA (rdata),
        .A     (a),
        .D_OUT (d_out),
        .D_OE  (d_oe),
        .D_IN  (d_in),
        ._AS   (as_n),
        ._UDS  (uds_n),
        ._LDS  (lds_n),
        ._PRW  (prw),
        ._DTACK(dtack_n)
    );

    // Per-offset observations, bit o = value in cycle k+o (k = accepting edge)
    logic [31:0] v_as, v_uds, v_lds, v_prw, v_doe, v_busy, v_done;
    int          done_off;
    logic        err_at_done;
    logic [15:0] rdata_at_done, dout_at_done;
    logic [22:0] a_at_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge in IDLE and record a fixed 31-cycle window
    task automatic run_txn(input logic t_rw, input logic [22:0] t_addr, input logic [15:0] t_wdata,
                           input logic [1:0] t_be, input int req_pulse_off, input int rst_off);
        v_as = '0; v_uds = '0; v_lds = '0; v_prw = '0; v_doe = '0; v_busy = '0; v_done = '0;
        done_off = -1; err_at_done = 1'b0; rdata_at_done = '0; dout_at_done = '0; a_at_done = '0;
        rw = t_rw; addr = t_addr; wdata = t_wdata; be = t_be; req = 1'b1;
        for (int o = 1; o < 32; o++) begin
            @(negedge clk);
            v_as[o] = as_n; v_uds[o] = uds_n; v_lds[o] = lds_n; v_prw[o] = prw;
            v_doe[o] = d_oe; v_busy[o] = busy; v_done[o] = done;
            if (done && done_off < 0) begin
                done_off      = o;
                err_at_done   = err;
                rdata_at_done = rdata;
                dout_at_done  = d_out;
                a_at_done     = a;
            end
            if (o == 1) req = 1'b0;
            if (o == req_pulse_off) req = 1'b1;
            if (o == req_pulse_off + 2) req = 1'b0;
            if (o == rst_off) rst_n = 1'b0;
            if (o == rst_off + 1) rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; rw = 1'b1; addr = '0; wdata = '0; be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_as",    32'(as_n),  32'h1);
        check("rst_uds",   32'(uds_n), 32'h1);
        check("rst_lds",   32'(lds_n), 32'h1);
        check("rst_prw",   32'(prw),   32'h1);
        check("rst_doe",   32'(d_oe),  32'h0);
        check("rst_stat",  32'({busy, done, err}), 32'h0);
        check("rst_a",     32'(a),     32'h0);
        check("rst_dout",  32'(d_out), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read, _DTACK straight from _AS
        resp_wait = 0; resp_never = 1'b0; resp_data = 16'h4AFC;
        run_txn(1'b1, 23'h7C0000, 16'h0000, BE_WORD, -10, -10);
        check("rd_done_off", 32'(done_off),    32'd6);
        check("rd_err",      32'(err_at_done), 32'h0);
        check("rd_rdata",    32'(rdata_at_done), 32'h4AFC);
        check("rd_a",        32'(a_at_done),   32'h7C0000);
        check("rd_as",       32'(v_as[7:1]),   32'b1100001);
        check("rd_uds",      32'(v_uds[7:1]),  32'b1100001);
        check("rd_lds",      32'(v_lds[7:1]),  32'b1100001);
        check("rd_prw",      32'(v_prw[7:1]),  32'b1111111);
        check("rd_doe",      32'(v_doe[7:1]),  32'b0000000);
        check("rd_busy",     32'(v_busy[7:1]), 32'b0111111);
        check("rd_done",     v_done,           32'h40);

        // Upper-byte write
        run_txn(1'b0, 23'h7C0002, 16'h1234, BE_UPPER, -10, -10);
        check("wr_done_off", 32'(done_off),     32'd6);
        check("wr_err",      32'(err_at_done),  32'h0);
        check("wr_dout",     32'(dout_at_done), 32'h1234);
        check("wr_rdata",    32'(rdata_at_done), 32'h4AFC);
        check("wr_as",       32'(v_as[7:1]),    32'b1100001);
        check("wr_uds",      32'(v_uds[7:1]),   32'b1100011);
        check("wr_lds",      32'(v_lds[7:1]),   32'b1111111);
        check("wr_prw",      32'(v_prw[6:1]),   32'b000000);
        check("wr_doe",      32'(v_doe[7:1]),   32'b0111110);

        // Read with three responder wait cycles; REQ pulsed mid-cycle is ignored
        resp_wait = 3; resp_data = 16'hBEEF;
        run_txn(1'b1, 23'h012345, 16'h0000, BE_LOWER, 3, -10);
        check("ws_done_off", 32'(done_off),      32'd9);
        check("ws_rdata",    32'(rdata_at_done), 32'hBEEF);
        check("ws_as",       32'(v_as[9:1]),     32'b100000001);
        check("ws_uds",      32'(v_uds[9:1]),    32'b111111111);
        check("ws_lds",      32'(v_lds[9:1]),    32'b100000001);
        check("ws_ndone",    32'($countones(v_done)), 32'd1);
        check("ws_no_2nd_as", 32'(v_as[31:10]),  32'h3FFFFF);
        check("ws_no_2nd_busy", 32'(v_busy[31:10]), 32'h0);

        // Responder never acknowledges
        resp_never = 1'b1; resp_wait = 0; resp_data = 16'h5555;
        run_txn(1'b1, 23'h054321, 16'h0000, BE_WORD, -10, -10);
        check("to_done_off", 32'(done_off),      32'd19);
        check("to_err",      32'(err_at_done),   32'h1);
        check("to_rdata",    32'(rdata_at_done), 32'hBEEF);
        check("to_a",        32'(a_at_done),     32'h054321);
        check("to_dout",     32'(dout_at_done),  32'h1234);
        check("to_strb_end", 32'({v_as[19], v_uds[19], v_lds[19]}), 32'b111);
        check("to_as_s4",    32'(v_as[18]),      32'h0);
        check("to_busy_after", 32'(v_busy[20]),  32'h0);
        check("to_ndone",    32'($countones(v_done)), 32'd1);
        resp_never = 1'b0;

        // Empty byte enable: error without bus activity
        run_txn(1'b0, 23'h0ABCDE, 16'hFFFF, BE_NONE, -10, -10);
        check("be0_done_off", 32'(done_off),    32'd2);
        check("be0_err",      32'(err_at_done), 32'h1);
        check("be0_as",       32'(v_as[4:1]),   32'b1111);
        check("be0_strb",     32'(v_uds[4:1] & v_lds[4:1]), 32'b1111);
        check("be0_doe",      32'(v_doe[4:1]),  32'b0000);
        check("be0_busy",     32'(v_busy[4:1]), 32'b0011);
        check("be0_a_hold",   32'(a_at_done),   32'h054321);

        // Reset asserted during S4 of a write
        run_txn(1'b0, 23'h000100, 16'hA5A5, BE_WORD, -10, 3);
        check("rs_pre_uds",   32'(v_uds[3]),   32'h0);
        check("rs_pre_doe",   32'(v_doe[3]),   32'h1);
        check("rs_strb",      32'({v_as[4], v_uds[4], v_lds[4]}), 32'b111);
        check("rs_doe",       32'(v_doe[4]),   32'h0);
        check("rs_busy",      32'(v_busy[4]),  32'h0);
        check("rs_no_done",   v_done,          32'h0);
        check("rs_done_off",  32'(done_off),   32'hFFFFFFFF);
        check("rs_rdata",     32'(rdata),      32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
